ps_axis_upsizer: RTL and testbench



---
 rtl/ps_axis_upsizer_pkg.sv | 7 +
 rtl/rfsoc_config.sv | 6 +
 rtl/ps_axis_upsizer.sv | 124 ++++++++++++
 tb/tb_ps_axis_upsizer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_axis_upsizer_pkg.sv
// Local types for the PS-to-DAC AXI-Stream upsizer.
package ps_axis_upsizer_pkg;
    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } upsizer_state_t;
endpackage

// File: rtl/rfsoc_config.sv
// Shared PL configuration constants for the RFSoC control fabric.
package rfsoc_config;
    localparam int ps_axis_width  = 32;
    localparam int dac_axis_width = 256;
    localparam int upsizer_ratio  = dac_axis_width / ps_axis_width;
endpackage

// File: rtl/ps_axis_upsizer.sv
// Packs RATIO narrow PS words into one wide DAC beat (word 0 in the LSBs); flush emits a zero-padded partial beat.
// Latency: beat valid the cycle after its last word (or the flush) is accepted; one word per cycle sustained.
// Backpressure: only the completing word (and a pending flush) waits for a free output slot.
module ps_axis_upsizer
    import rfsoc_config::*;
    import ps_axis_upsizer_pkg::*;
#(
    parameter  int IN_WIDTH  = ps_axis_width,
    parameter  int OUT_WIDTH = dac_axis_width,
    localparam int RATIO     = OUT_WIDTH / IN_WIDTH,
    localparam int PEND_W    = $clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [PEND_W-1:0]    words_pending,
    output logic [31:0]          beat_count
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RATIO - 1);

    if (OUT_WIDTH % IN_WIDTH != 0) begin : g_bad_ratio
        $error("ps_axis_upsizer: OUT_WIDTH must be a multiple of IN_WIDTH");
    end

    upsizer_state_t       state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] acc_merged;
    logic [OUT_WIDTH-1:0] dat_d;
    logic                 vld_d;
    logic [31:0]          beat_d;
    logic                 slot_free;
    logic                 accept;

    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && (state_q == FILL) && ((idx_q != LAST) || slot_free);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign words_pending = PEND_W'(idx_q);

    // Accumulator as it stands once this cycle's word (if any) is packed in.
    always_comb begin
        acc_merged = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (accept && (idx_q == IDX_W'(k))) begin
                acc_merged[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        dat_d   = m_axis_tdata;
        vld_d   = m_axis_tvalid && !m_axis_tready;
        beat_d  = beat_count;
        case (state_q)
            FILL: begin
                if (accept && (idx_q == LAST)) begin
                    // A completing word swallows any same-cycle flush.
                    dat_d  = acc_merged;
                    vld_d  = 1'b1;
                    acc_d  = '0;
                    idx_d  = '0;
                    beat_d = beat_count + 32'd1;
                end else begin
                    if (accept) begin
                        acc_d = acc_merged;
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (flush && (accept || (idx_q != '0))) begin
                        if (slot_free) begin
                            dat_d  = acc_merged;
                            vld_d  = 1'b1;
                            acc_d  = '0;
                            idx_d  = '0;
                            beat_d = beat_count + 32'd1;
                        end else begin
                            state_d = FLUSH_WAIT;
                        end
                    end
                end
            end
            FLUSH_WAIT: begin
                if (slot_free) begin
                    dat_d   = acc_q;
                    vld_d   = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    beat_d  = beat_count + 32'd1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            idx_q         <= '0;
            acc_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            beat_count    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            m_axis_tdata  <= dat_d;
            m_axis_tvalid <= vld_d;
            beat_count    <= beat_d;
        end
    end

endmodule

// File: tb/tb_ps_axis_upsizer.sv
// Bench for ps_axis_upsizer: per-cycle vector table plus scoreboard of expected beats.
module tb_ps_axis_upsizer;
    localparam int W  = 32;
    localparam int OW = 256;
    localparam int R  = OW / W;
    localparam int PW = $clog2(R) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [PW-1:0] words_pending;
    logic [31:0]   beat_count;

    always #5 clk = ~clk;

    ps_axis_upsizer #(.IN_WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .words_pending (words_pending),
        .beat_count    (beat_count)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        fl;
        logic        r;
        logic        e_tr;
        int          e_pend;
        logic        e_vld;
    } vec_t;

    vec_t          tbl[$];
    logic [OW-1:0] exp_q[$];
    logic [W-1:0]  mwords[R];
    int            mn     = 0;
    int            mbeats = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic model_push();
        logic [OW-1:0] b;
        b = '0;
        for (int k = 0; k < mn; k++) b[k*W +: W] = mwords[k];
        exp_q.push_back(b);
        mbeats++;
        mn = 0;
    endtask

    // Scoreboard: every downstream handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got 0x%h, expected no beat", m_axis_tdata);
            end else begin
                chk_beat("beat_data", m_axis_tdata, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic fl, input logic r,
                        output logic tr);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        flush         = fl;
        m_axis_tready = r;
        #1;
        tr = s_axis_tready;
        if (v && tr) begin
            mwords[mn] = d;
            mn++;
            if (mn == R) model_push();
        end
        if (fl && mn != 0) model_push();
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        flush         = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("tready_in_reset", s_axis_tready, 1'b0);
        @(posedge clk);
        #1;
        exp_q.delete();
        mn     = 0;
        mbeats = 0;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_pending", words_pending, 0);
        chk("rst_beat_count", beat_count, 0);
        rst = 1'b0;
        #1;
        chk("tready_after_reset", s_axis_tready, 1'b1);
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic fl, input logic r,
                       input logic e_tr, input int e_pend, input logic e_vld);
        vec_t e;
        e.v = v; e.d = d; e.fl = fl; e.r = r;
        e.e_tr = e_tr; e.e_pend = e_pend; e.e_vld = e_vld;
        tbl.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          tr;
        logic          vld0;
        logic [OW-1:0] dat0;
        int            stalls;
        int            gaps;

        // Vector table: backpressure, flush with free/busy slot, flush corner cases.
        for (int k = 1; k <= 7; k++) add(1, k, 0, 1, 1, k, 0);
        add(1, 8, 0, 1, 1, 0, 1);
        for (int k = 9; k <= 15; k++) add(1, k, 0, 0, 1, k - 8, 1);
        add(1, 16, 0, 0, 0, 7, 1);
        add(1, 16, 0, 0, 0, 7, 1);
        add(1, 16, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(1, 'hA, 0, 1, 1, 1, 0);
        add(1, 'hB, 0, 1, 1, 2, 0);
        add(1, 'hC, 0, 1, 1, 3, 0);
        add(0, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(1, 'hA, 0, 0, 1, 1, 0);
        add(1, 'hB, 0, 0, 1, 2, 0);
        add(1, 'hC, 0, 0, 1, 3, 0);
        add(0, 0, 1, 0, 1, 0, 1);
        add(1, 'hD, 0, 0, 1, 1, 1);
        add(1, 'hE, 0, 0, 1, 2, 1);
        add(0, 0, 1, 0, 1, 2, 1);
        add(1, 'hF, 0, 0, 0, 2, 1);
        add(1, 'hF, 0, 1, 0, 0, 1);
        add(1, 'hF, 0, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(1, 'h100 + k, 0, 1, 1, k + 1, 0);
        add(1, 'h107, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(1, 'h200, 0, 1, 1, 1, 0);
        add(1, 'h201, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0);

        @(posedge clk);
        #1;
        do_reset();

        // Basic packing and latency.
        for (int k = 1; k <= 7; k++) step(1, k, 0, 1, tr);
        chk("basic_vld_before_last", m_axis_tvalid, 1'b0);
        step(1, 8, 0, 1, tr);
        chk("basic_vld_latency", m_axis_tvalid, 1'b1);
        chk_beat("basic_beat_literal", m_axis_tdata,
                 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        chk("basic_beat_count", beat_count, 1);
        step(0, 0, 0, 1, tr);
        chk("basic_drained", exp_q.size(), 0);

        // Streaming: 64 words back-to-back.
        do_reset();
        stalls = 0;
        gaps   = 0;
        for (int i = 0; i < 64; i++) begin
            step(1, 32'h1000 + i, 0, 1, tr);
            if (!tr) stalls++;
            if (m_axis_tvalid !== ((i % 8) == 7)) gaps++;
        end
        step(0, 0, 0, 1, tr);
        chk("stream_stalls", stalls, 0);
        chk("stream_gaps", gaps, 0);
        chk("stream_beat_count", beat_count, 8);
        chk("stream_drained", exp_q.size(), 0);

        // Table-driven vectors.
        do_reset();
        foreach (tbl[i]) begin
            vld0 = m_axis_tvalid;
            dat0 = m_axis_tdata;
            step(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].r, tr);
            chk($sformatf("vec%0d_tready", i), tr, tbl[i].e_tr);
            chk($sformatf("vec%0d_pending", i), words_pending, tbl[i].e_pend);
            chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, tbl[i].e_vld);
            if (vld0 && !tbl[i].r) chk_beat($sformatf("vec%0d_hold", i), m_axis_tdata, dat0);
        end
        chk("table_drained", exp_q.size(), 0);
        chk("table_beat_count", beat_count, mbeats);

        // Reset with a stalled beat and 5 words pending.
        do_reset();
        for (int k = 0; k < 13; k++) step(1, 32'h500 + k, 0, 0, tr);
        chk("midrst_pending", words_pending, 5);
        chk("midrst_stalled", m_axis_tvalid, 1'b1);
        do_reset();
        for (int k = 0; k < 8; k++) step(1, 32'h300 + k, 0, 1, tr);
        step(0, 0, 0, 1, tr);
        chk("postrst_beat_count", beat_count, 1);
        chk("postrst_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
